// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl -- CPU-to-peripheral bus controller.
//
// Decodes each CPU access into one of N_SLV address windows. If several windows
// match, the lowest index wins. It then runs a registered select/ack handshake
// with that slot and returns one cpu_ready pulse per access. One slot
// (SHARED_SLOT) is shared with the display reader. While disp_busy is high, that
// slot's select is masked, so the display always has priority.
//
// Optional feature: define MIO_BUS_TIMEOUT_EN to add an 8-bit ack timeout. When
// it expires, the access ends with cpu_err and ERR_DATA.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   cpu_req/we/addr  CPU request. cpu_req is held high until cpu_ready.
//   cpu_wdata        CPU write data
//   cpu_rdata        read data, valid with cpu_ready, held until the next capture
//   cpu_ready        one-cycle completion pulse
//   cpu_err          unmapped address or timeout, valid with cpu_ready
//   disp_busy        display owns the shared slot
//   slv_sel          one-hot slot select, held until ack
//   slv_we           write strobe, qualified by slv_sel
//   slv_addr/wdata   registered address / write data
//   slv_rdata        packed per-slot read data
//   slv_ack          per-slot completion
module mio_bus_ctrl #(
    parameter int                       N_SLV       = 4,
    parameter int                       ADDR_W      = 32,
    parameter int                       DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0]  SLV_BASE    = {32'h000E_0100, 32'h000E_0100,
                                                       32'h000C_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0]  SLV_MASK    = {32'hFFFF_FF00, 32'hFFFF_FF80,
                                                       32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                       SHARED_SLOT = 1,
    parameter int                       TIMEOUT     = 255,
    parameter logic [DATA_W-1:0]        ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_err,
    input  logic                      disp_busy,
    output logic [N_SLV-1:0]          slv_sel,
    output logic                      slv_we,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
    input  logic [N_SLV-1:0]          slv_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N_SLV-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // One-hot mask of the shared slot. It is built with a loop so that
    // SHARED_SLOT == N_SLV (sharing disabled) yields an all-zero mask.
    logic [N_SLV-1:0] share_mask;
    always_comb begin
        share_mask = '0;
        for (int i = 0; i < N_SLV; i++)
            if (i == SHARED_SLOT) share_mask[i] = 1'b1;
    end

    // The select the slaves actually see. The display steals the shared slot.
    logic [N_SLV-1:0] eff_sel;
    assign eff_sel = sel_q & ~(share_mask & {N_SLV{disp_busy}});

    // Only an ack on a visibly selected slot counts. Acks on other slots, or on
    // the masked shared slot, are ignored.
    logic              ack_hit;
    logic [DATA_W-1:0] rd_mux;
    assign ack_hit = |(slv_ack & eff_sel);
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SLV; i++)
            if (eff_sel[i] && slv_ack[i]) rd_mux = slv_rdata[i*DATA_W +: DATA_W];
    end

    // Address decode with lowest-index priority.
    logic [N_SLV-1:0] hit;
    logic             found;
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found &&
                ((cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    logic tmo;
`ifdef MIO_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    // Fires on the TIMEOUT-th visibly selected cycle without an ack. An ack in
    // the same cycle takes precedence.
    assign tmo = (|eff_sel) && !ack_hit && (cnt_q == 8'(TIMEOUT - 1));
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE)
            cnt_d = '0;
        else if (state_q == S_ACCESS && (|eff_sel) && !ack_hit)
            cnt_d = cnt_q + 8'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we & found;
                    if (found) begin
                        sel_d   = hit;
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        state_d = S_RESP;
                    end
                end
            end
            S_ACCESS: begin
                if (ack_hit) begin
                    rdata_d = we_q ? '0 : rd_mux;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_RESP;
                end else if (tmo) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_ready = (state_q == S_RESP);
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign slv_sel   = eff_sel;
    assign slv_we    = we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;

endmodule
